// File: rtl/mul_operand_loader.sv
// Byte-serial operand loader: assembles operands A and B (little-endian) from a byte stream,
// holds them on the multiplier request port, and turns abort into a flush pulse. Optional idle timeout: MUL_LOADER_TIMEOUT_EN.
module mul_operand_loader #(
    parameter int WIDTH          = 32,
    parameter int TIMEOUT_CYCLES = 1024,
    localparam int NB            = 2 * WIDTH / 8,
    localparam int CW            = $clog2(NB + 1)
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [7:0]       byte_i,
    input  logic             byte_valid_i,
    output logic             byte_ready_o,
    input  logic             abort_i,
    output logic [CW-1:0]    count_o,
    output logic [WIDTH-1:0] a_o,
    output logic [WIDTH-1:0] b_o,
    output logic             req_o,
    input  logic             ready_i,
    output logic             flush_o,
    output logic             timeout_o,
    output logic             state_dbg_o
);

    if ((WIDTH % 8) != 0 || TIMEOUT_CYCLES < 1) begin : g_param_check
        $error("mul_operand_loader: WIDTH must be a multiple of 8 and TIMEOUT_CYCLES >= 1");
    end

    typedef enum logic {
        LOAD  = 1'b0,
        ISSUE = 1'b1
    } state_t;

    // Handshake: in ISSUE req_o stays high with a_o/b_o stable until the edge where ready_i=1;
    // in LOAD byte_ready_o is high and each edge with byte_valid_i=1 captures one byte.
    state_t             state, state_n;
    logic [CW-1:0]      count, count_n;
    logic [2*WIDTH-1:0] data, data_n;
    logic               flush, flush_n;

`ifdef MUL_LOADER_TIMEOUT_EN
    localparam int IW = $clog2(TIMEOUT_CYCLES + 1);
    logic [IW-1:0] idle, idle_n;
    logic          timeout, timeout_n;
`endif

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state <= LOAD;
            count <= '0;
            data  <= '0;
            flush <= 1'b0;
`ifdef MUL_LOADER_TIMEOUT_EN
            idle    <= '0;
            timeout <= 1'b0;
`endif
        end else begin
            state <= state_n;
            count <= count_n;
            data  <= data_n;
            flush <= flush_n;
`ifdef MUL_LOADER_TIMEOUT_EN
            idle    <= idle_n;
            timeout <= timeout_n;
`endif
        end
    end

    always_comb begin
        state_n = state;
        count_n = count;
        data_n  = data;
        flush_n = 1'b0;
`ifdef MUL_LOADER_TIMEOUT_EN
        idle_n    = idle;
        timeout_n = 1'b0;
`endif
        // Abort wins over both byte capture and the ready handshake.
        if (abort_i) begin
            state_n = LOAD;
            count_n = '0;
            flush_n = 1'b1;
`ifdef MUL_LOADER_TIMEOUT_EN
            idle_n = '0;
`endif
        end else begin
            unique case (state)
                LOAD: begin
                    if (byte_valid_i) begin
                        for (int i = 0; i < NB; i++) begin
                            if (count == CW'(i)) data_n[i*8 +: 8] = byte_i;
                        end
`ifdef MUL_LOADER_TIMEOUT_EN
                        idle_n = '0;
`endif
                        if (count == CW'(NB - 1)) begin
                            count_n = '0;
                            state_n = ISSUE;
                        end else begin
                            count_n = count + CW'(1);
                        end
                    end
`ifdef MUL_LOADER_TIMEOUT_EN
                    else if (count != '0) begin
                        if (idle == IW'(TIMEOUT_CYCLES - 1)) begin
                            count_n   = '0;
                            idle_n    = '0;
                            timeout_n = 1'b1;
                        end else begin
                            idle_n = idle + IW'(1);
                        end
                    end
`endif
                end
                ISSUE: begin
                    if (ready_i) state_n = LOAD;
                end
                default: state_n = LOAD;
            endcase
        end
    end

    assign byte_ready_o = (state == LOAD);
    assign req_o        = (state == ISSUE);
    assign state_dbg_o  = state;
    assign count_o      = count;
    assign a_o          = data[WIDTH-1:0];
    assign b_o          = data[2*WIDTH-1:WIDTH];
    assign flush_o      = flush;
`ifdef MUL_LOADER_TIMEOUT_EN
    assign timeout_o    = timeout;
`else
    assign timeout_o    = 1'b0;
`endif

endmodule

// File: tb/tb_mul_operand_loader.sv
// Self-checking bench for mul_operand_loader: vector table, directed corner sequences,
// and randomized traffic checked against a byte-lane reference model.
module tb_mul_operand_loader;

    localparam int WIDTH = 32;
    localparam int TO    = 16;
    localparam int NB    = 2 * WIDTH / 8;
    localparam int CW    = $clog2(NB + 1);

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic [7:0]       byte_in = '0;
    logic             byte_valid = 1'b0;
    logic             byte_ready;
    logic             abort = 1'b0;
    logic [CW-1:0]    count;
    logic [WIDTH-1:0] a, b;
    logic             req;
    logic             ready = 1'b0;
    logic             flush;
    logic             timeout;
    logic             state_dbg;

    mul_operand_loader #(.WIDTH(WIDTH), .TIMEOUT_CYCLES(TO)) dut (
        .clk_i(clk), .rst_i(rst), .byte_i(byte_in), .byte_valid_i(byte_valid),
        .byte_ready_o(byte_ready), .abort_i(abort), .count_o(count),
        .a_o(a), .b_o(b), .req_o(req), .ready_i(ready), .flush_o(flush),
        .timeout_o(timeout), .state_dbg_o(state_dbg)
    );

    always #5 clk = ~clk;

    int total = 0;
    int passed = 0;

    // Reference model: the bytes sitting in each lane, how many of the current load
    // have arrived, and whether an operation is waiting for the multiplier.
    logic [7:0] m_lanes[NB];
    int         m_got;
    bit         m_waiting;
    bit         m_flush;
    bit         m_timeout;
    int         m_idle;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        else passed++;
    endtask

    task automatic model_reset();
        for (int i = 0; i < NB; i++) m_lanes[i] = 8'h00;
        m_got = 0; m_waiting = 0; m_flush = 0; m_timeout = 0; m_idle = 0;
    endtask

    function automatic logic [WIDTH-1:0] model_operand(input int first);
        logic [WIDTH-1:0] v = '0;
        for (int i = 0; i < NB / 2; i++) v[i*8 +: 8] = m_lanes[first + i];
        return v;
    endfunction

    task automatic model_edge(input bit bv, input logic [7:0] bt, input bit ab, input bit rdy);
        m_flush = 0;
        m_timeout = 0;
        if (ab) begin
            m_got = 0; m_waiting = 0; m_flush = 1; m_idle = 0;
        end else if (m_waiting) begin
            if (rdy) m_waiting = 0;
        end else if (bv) begin
            m_lanes[m_got] = bt;
            m_got++;
            m_idle = 0;
            if (m_got == NB) begin
                m_got = 0;
                m_waiting = 1;
            end
        end else if (m_got != 0) begin
`ifdef MUL_LOADER_TIMEOUT_EN
            m_idle++;
            if (m_idle == TO) begin
                m_got = 0; m_idle = 0; m_timeout = 1;
            end
`endif
        end
    endtask

    task automatic compare_model(input string tag);
        check({tag, ".byte_ready"}, 64'(byte_ready), 64'(!m_waiting));
        check({tag, ".req"},        64'(req),        64'(m_waiting));
        check({tag, ".count"},      64'(count),      64'(m_got));
        check({tag, ".a"},          64'(a),          64'(model_operand(0)));
        check({tag, ".b"},          64'(b),          64'(model_operand(NB / 2)));
        check({tag, ".flush"},      64'(flush),      64'(m_flush));
        check({tag, ".timeout"},    64'(timeout),    64'(m_timeout));
    endtask

    // Inputs are set at edge+1; this samples them at the edge and compares at edge+1.
    task automatic cycle(input bit bv, input logic [7:0] bt, input bit ab, input bit rdy, input string tag);
        byte_valid = bv; byte_in = bt; abort = ab; ready = rdy;
        @(posedge clk);
        model_edge(bv, bt, ab, rdy);
        #1;
        compare_model(tag);
    endtask

    task automatic load8(input logic [63:0] bytes_le, input bit rdy, input string tag);
        for (int i = 0; i < NB; i++) cycle(1'b1, bytes_le[i*8 +: 8], 1'b0, rdy, tag);
    endtask

    task automatic idle_cycle(input string tag);
        cycle(1'b0, 8'h00, 1'b0, 1'b0, tag);
    endtask

    typedef struct {
        bit            bv;
        logic [7:0]    bt;
        bit            ab;
        bit            rdy;
        bit            exp_req;
        logic [CW-1:0] exp_count;
        bit            exp_flush;
    } vec_t;

    vec_t vecs[10];

    initial begin
        vecs[0] = '{1, 8'h78, 0, 1, 0, 4'd1, 0};
        vecs[1] = '{1, 8'h56, 0, 1, 0, 4'd2, 0};
        vecs[2] = '{1, 8'h34, 0, 1, 0, 4'd3, 0};
        vecs[3] = '{1, 8'h12, 0, 1, 0, 4'd4, 0};
        vecs[4] = '{1, 8'h04, 0, 1, 0, 4'd5, 0};
        vecs[5] = '{1, 8'h03, 0, 1, 0, 4'd6, 0};
        vecs[6] = '{1, 8'h02, 0, 1, 0, 4'd7, 0};
        vecs[7] = '{1, 8'h01, 0, 1, 1, 4'd0, 0};
        vecs[8] = '{0, 8'h00, 0, 1, 0, 4'd0, 0};
        vecs[9] = '{0, 8'h00, 1, 0, 0, 4'd0, 1};

        model_reset();
        #13;
        check("reset.byte_ready", 64'(byte_ready), 64'd1);
        check("reset.req",        64'(req),        64'd0);
        check("reset.count",      64'(count),      64'd0);
        check("reset.a",          64'(a),          64'd0);
        check("reset.b",          64'(b),          64'd0);
        check("reset.flush",      64'(flush),      64'd0);
        check("reset.timeout",    64'(timeout),    64'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        // Basic load with ready held high, then an abort in empty LOAD.
        for (int i = 0; i < 10; i++) begin
            cycle(vecs[i].bv, vecs[i].bt, vecs[i].ab, vecs[i].rdy, "vec");
            check("vec.req",   64'(req),   64'(vecs[i].exp_req));
            check("vec.count", 64'(count), 64'(vecs[i].exp_count));
            check("vec.flush", 64'(flush), 64'(vecs[i].exp_flush));
            if (i == 7) begin
                check("vec.a_value", 64'(a), 64'h12345678);
                check("vec.b_value", 64'(b), 64'h01020304);
            end
        end
        idle_cycle("after_abort");
        check("abort_pulse_one_cycle", 64'(flush), 64'd0);

        // Multiplier stalls for 5 cycles; bytes driven meanwhile must be dropped.
        load8(64'h01020304_12345678, 1'b0, "stall_load");
        check("stall.req_after_load", 64'(req), 64'd1);
        for (int i = 0; i < 5; i++) begin
            cycle(1'b1, (i % 2 == 0) ? 8'hAA : 8'hBB, 1'b0, 1'b0, "stall");
            check("stall.req_held", 64'(req), 64'd1);
            check("stall.count_zero", 64'(count), 64'd0);
            check("stall.a_stable", 64'(a), 64'h12345678);
            check("stall.b_stable", 64'(b), 64'h01020304);
        end
        cycle(1'b0, 8'h00, 1'b0, 1'b1, "stall_release");
        check("stall.req_dropped", 64'(req), 64'd0);

        // Partial load aborted alongside a valid byte, then a fresh full load.
        for (int i = 0; i < 3; i++) cycle(1'b1, 8'hC0 + 8'(i), 1'b0, 1'b0, "partial");
        check("partial.count3", 64'(count), 64'd3);
        cycle(1'b1, 8'hEE, 1'b1, 1'b0, "partial_abort");
        check("partial_abort.count", 64'(count), 64'd0);
        check("partial_abort.flush", 64'(flush), 64'd1);
        load8(64'h08070605_04030201, 1'b0, "reload");
        check("reload.a", 64'(a), 64'h04030201);
        check("reload.b", 64'(b), 64'h08070605);
        check("reload.flush_low", 64'(flush), 64'd0);

        // Abort in ISSUE on the same cycle as ready.
        cycle(1'b0, 8'h00, 1'b1, 1'b1, "issue_abort");
        check("issue_abort.req", 64'(req), 64'd0);
        check("issue_abort.flush", 64'(flush), 64'd1);
        idle_cycle("issue_abort_next");
        check("issue_abort.flush_once", 64'(flush), 64'd0);

        // Back-to-back aborts keep flush high on each following cycle.
        cycle(1'b0, 8'h00, 1'b1, 1'b0, "b2b_abort0");
        cycle(1'b0, 8'h00, 1'b1, 1'b0, "b2b_abort1");
        check("b2b.flush_second", 64'(flush), 64'd1);
        idle_cycle("b2b_end");

        // Asynchronous reset mid-load (count 5) and mid-ISSUE.
        for (int i = 0; i < 5; i++) cycle(1'b1, 8'h50 + 8'(i), 1'b0, 1'b0, "pre_reset");
        check("pre_reset.count5", 64'(count), 64'd5);
        #3 rst = 1'b1;
        #1;
        model_reset();
        compare_model("async_reset_load");
        #2 rst = 1'b0;
        idle_cycle("post_reset_load");
        load8(64'h11223344_55667788, 1'b0, "pre_reset_issue");
        check("pre_reset_issue.req", 64'(req), 64'd1);
        #3 rst = 1'b1;
        #1;
        model_reset();
        compare_model("async_reset_issue");
        check("async_reset_issue.req", 64'(req), 64'd0);
        #2 rst = 1'b0;
        idle_cycle("post_reset_issue");

        // Idle timeout boundaries; without the option a partial load must simply wait.
        for (int i = 0; i < 2; i++) cycle(1'b1, 8'hD0 + 8'(i), 1'b0, 1'b0, "to_load");
        for (int i = 0; i < TO; i++) idle_cycle("to_idle");
`ifdef MUL_LOADER_TIMEOUT_EN
        check("timeout.pulse", 64'(timeout), 64'd1);
        check("timeout.count", 64'(count), 64'd0);
        check("timeout.flush", 64'(flush), 64'd0);
        for (int i = 0; i < 2; i++) cycle(1'b1, 8'hD0 + 8'(i), 1'b0, 1'b0, "to_reload");
`else
        check("no_timeout.pulse", 64'(timeout), 64'd0);
        check("no_timeout.count_held", 64'(count), 64'd2);
`endif
        for (int i = 0; i < TO - 1; i++) idle_cycle("to_idle15");
        cycle(1'b1, 8'hD2, 1'b0, 1'b0, "to_byte3");
        check("idle15.count3", 64'(count), 64'd3);
        check("idle15.no_timeout", 64'(timeout), 64'd0);
        cycle(1'b0, 8'h00, 1'b1, 1'b0, "to_clear");

        // Randomized traffic against the model.
        for (int i = 0; i < 400; i++) begin
            cycle($urandom_range(0, 9) < 7, 8'($urandom), $urandom_range(0, 19) == 0,
                  $urandom_range(0, 2) == 0, "rand");
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
